// File: rtl/wsn_mem_pkg.sv
// rtl/wsn_mem_pkg.sv - routing memory map, status codes and neighbour writer FSM states
package wsn_mem_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH  = 2048;
  localparam int MAX_NBR    = 64;

  localparam logic [15:0] NBR_ID_BASE  = 16'h0048;
  localparam logic [15:0] CLUSTER_BASE = 16'h00C8;
  localparam logic [15:0] BATT_BASE    = 16'h0148;
  localparam logic [15:0] QVAL_BASE    = 16'h01C8;
  localparam logic [15:0] NBR_CNT_ADDR = 16'h068A;

  typedef enum logic [1:0] {
    STAT_UPDATED  = 2'b00,
    STAT_APPENDED = 2'b01,
    STAT_DROPPED  = 2'b10
  } status_t;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_SCAN, S_WR_ID, S_WR_CL, S_WR_BAT, S_WR_Q, S_WR_CNT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    TBL_ID, TBL_CL, TBL_BAT, TBL_Q, TBL_CNT
  } tbl_t;

endpackage

// File: rtl/nbr_addr_gen.sv
// rtl/nbr_addr_gen.sv - maps (table select, entry index) to a byte address in the routing memory
module nbr_addr_gen
  import wsn_mem_pkg::*;
(
  input  tbl_t                  tbl,
  input  logic [5:0]            idx,
  output logic [WORD_WIDTH-1:0] address
);

  // Entries are 16-bit words, so the byte offset is twice the index; no wrap at 16 bits.
  logic [15:0] offset;
  assign offset = {9'd0, idx, 1'b0};

  always_comb begin
    address = '0;
    case (tbl)
      TBL_ID:  address = NBR_ID_BASE + offset;
      TBL_CL:  address = CLUSTER_BASE + offset;
      TBL_BAT: address = BATT_BASE + offset;
      TBL_Q:   address = QVAL_BASE + offset;
      TBL_CNT: address = NBR_CNT_ADDR;
      default: address = '0;
    endcase
  end

endmodule

// File: rtl/nbr_table_writer.sv
// rtl/nbr_table_writer.sv - scans the neighbour table for a reported ID, then updates or appends it
module nbr_table_writer
  import wsn_mem_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_id,
  input  logic [WORD_WIDTH-1:0] in_cluster,
  input  logic [WORD_WIDTH-1:0] in_battery,
  input  logic [WORD_WIDTH-1:0] in_qvalue,
  output logic [WORD_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  done,
  output logic [1:0]            status
);

  localparam logic [6:0] CNT_FULL = 7'(MAX_NBR);

  state_t                state;
  status_t               status_q;
  logic [6:0]            idx;
  logic [6:0]            cnt;
  logic                  is_new;
  logic [WORD_WIDTH-1:0] lat_id, lat_cluster, lat_battery, lat_qvalue;

  tbl_t                  tbl;
  logic                  addr_en;
  logic [WORD_WIDTH-1:0] gen_address;

  // idx needs a 7th bit only to reach cnt==64 in SCAN; addressed entries are always below 64.
  nbr_addr_gen u_addr_gen (
    .tbl     (tbl),
    .idx     (idx[5:0]),
    .address (gen_address)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      status_q    <= STAT_UPDATED;
      idx         <= '0;
      cnt         <= '0;
      is_new      <= 1'b0;
      lat_id      <= '0;
      lat_cluster <= '0;
      lat_battery <= '0;
      lat_qvalue  <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          lat_id      <= in_id;
          lat_cluster <= in_cluster;
          lat_battery <= in_battery;
          lat_qvalue  <= in_qvalue;
          state       <= S_RD_CNT;
        end
        S_RD_CNT: begin
          cnt   <= (mem_rdata > {9'd0, CNT_FULL}) ? CNT_FULL : mem_rdata[6:0];
          idx   <= '0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (idx == cnt) begin
            if (cnt == CNT_FULL) begin
              status_q <= STAT_DROPPED;
              state    <= S_DONE;
            end else begin
              is_new <= 1'b1;
              state  <= S_WR_ID;
            end
          end else if (mem_rdata == lat_id) begin
            is_new <= 1'b0;
            state  <= S_WR_CL;
          end else begin
            idx <= idx + 7'd1;
          end
        end
        S_WR_ID:  state <= S_WR_CL;
        S_WR_CL:  state <= S_WR_BAT;
        S_WR_BAT: state <= S_WR_Q;
        S_WR_Q: begin
          status_q <= is_new ? STAT_APPENDED : STAT_UPDATED;
          state    <= is_new ? S_WR_CNT : S_DONE;
        end
        S_WR_CNT: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tbl       = TBL_ID;
    addr_en   = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state)
      S_RD_CNT: begin tbl = TBL_CNT; addr_en = 1'b1; end
      S_SCAN:   addr_en = (idx != cnt);
      S_WR_ID:  begin addr_en = 1'b1; mem_wr_en = 1'b1; mem_wdata = lat_id; end
      S_WR_CL:  begin tbl = TBL_CL;  addr_en = 1'b1; mem_wr_en = 1'b1; mem_wdata = lat_cluster; end
      S_WR_BAT: begin tbl = TBL_BAT; addr_en = 1'b1; mem_wr_en = 1'b1; mem_wdata = lat_battery; end
      S_WR_Q:   begin tbl = TBL_Q;   addr_en = 1'b1; mem_wr_en = 1'b1; mem_wdata = lat_qvalue; end
      S_WR_CNT: begin tbl = TBL_CNT; addr_en = 1'b1; mem_wr_en = 1'b1; mem_wdata = {9'd0, cnt + 7'd1}; end
      default:  ;
    endcase
  end

  assign mem_address = addr_en ? gen_address : '0;
  assign in_ready    = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign status      = status_q;

endmodule

// File: tb/tb_nbr_table_writer.sv
// tb/tb_nbr_table_writer.sv - directed self-checking bench for nbr_table_writer with a byte memory model
module tb_nbr_table_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_id = '0, in_cluster = '0, in_battery = '0, in_qvalue = '0;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        done;
  logic [1:0]  status;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  mem [0:2047] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] wlog_a[$];
  logic [15:0] wlog_d[$];
  int          wbase = 0;
  int          lat;
  logic [1:0]  st;

  nbr_table_writer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_id       (in_id),
    .in_cluster  (in_cluster),
    .in_battery  (in_battery),
    .in_qvalue   (in_qvalue),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .done        (done),
    .status      (status)
  );

  always #5 clock = ~clock;

  // Big-endian word memory: high byte at the even address.
  assign mem_rdata = {mem[mem_address[10:0]], mem[mem_address[10:0] + 11'd1]};

  always @(posedge clock) begin
    if (pl_en) begin
      mem[pl_addr]         <= pl_data[15:8];
      mem[pl_addr + 11'd1] <= pl_data[7:0];
    end
    if (mem_wr_en) begin
      mem[mem_address[10:0]]         <= mem_wdata[15:8];
      mem[mem_address[10:0] + 11'd1] <= mem_wdata[7:0];
      wlog_a.push_back(mem_address);
      wlog_d.push_back(mem_wdata);
    end
  end

  function automatic logic [15:0] rd_word(input logic [15:0] a);
    return {mem[a[10:0]], mem[a[10:0] + 11'd1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int k, input logic [15:0] ea, input logic [15:0] ed);
    if (wbase + k < wlog_a.size()) begin
      check({tag, "_addr"}, 32'(wlog_a[wbase + k]), 32'(ea));
      check({tag, "_data"}, 32'(wlog_d[wbase + k]), 32'(ed));
    end else begin
      check({tag, "_present"}, 32'(wlog_a.size()), 32'(wbase + k + 1));
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_addr = a[10:0];
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    pl_en   = 1'b0;
  endtask

  task automatic wait_done(output int l, output logic [1:0] s);
    l = -1;
    s = 2'b11;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (done) begin
        l = c;
        s = status;
        break;
      end
    end
  endtask

  task automatic send(input string tag, input logic [15:0] id, input logic [15:0] cl,
                      input logic [15:0] bat, input logic [15:0] q,
                      output int l, output logic [1:0] s);
    @(negedge clock);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_id = id; in_cluster = cl; in_battery = bat; in_qvalue = q;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    wait_done(l, s);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready",  32'(in_ready), 32'd1);
    check("rst_wr_en",  32'(mem_wr_en), 32'd0);
    check("rst_addr",   32'(mem_address), 32'd0);
    check("rst_wdata",  32'(mem_wdata), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    reset = 1'b0;

    preload(16'h068A, 16'd4);
    preload(16'h0048, 16'd1);
    preload(16'h004A, 16'd3);
    preload(16'h004C, 16'd4);
    preload(16'h004E, 16'd6);

    // T1: update of the entry at index 2
    wbase = wlog_a.size();
    send("t1", 16'd4, 16'd2, 16'h4000, 16'h0500, lat, st);
    check("t1_lat", 32'(lat), 32'd8);
    check("t1_status", 32'(st), 32'd0);
    check("t1_nwr", 32'(wlog_a.size() - wbase), 32'd3);
    check_wr("t1_w0", 0, 16'h00CC, 16'd2);
    check_wr("t1_w1", 1, 16'h014C, 16'h4000);
    check_wr("t1_w2", 2, 16'h01CC, 16'h0500);
    check("t1_cnt", 32'(rd_word(16'h068A)), 32'd4);

    // T5: reset during the second SCAN cycle of the append report
    wbase = wlog_a.size();
    @(negedge clock);
    in_id = 16'd9; in_cluster = 16'd7; in_battery = 16'h2000; in_qvalue = 16'h0100;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("t5_ready", 32'(in_ready), 32'd1);
    check("t5_wr_en", 32'(mem_wr_en), 32'd0);
    check("t5_done",  32'(done), 32'd0);
    check("t5_addr",  32'(mem_address), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("t5_nwr", 32'(wlog_a.size() - wbase), 32'd0);
    check("t5_cnt", 32'(rd_word(16'h068A)), 32'd4);

    // T2: append at index 4
    wbase = wlog_a.size();
    send("t2", 16'd9, 16'd7, 16'h2000, 16'h0100, lat, st);
    check("t2_lat", 32'(lat), 32'd12);
    check("t2_status", 32'(st), 32'd1);
    check("t2_nwr", 32'(wlog_a.size() - wbase), 32'd5);
    check_wr("t2_w0", 0, 16'h0050, 16'd9);
    check_wr("t2_w1", 1, 16'h00D0, 16'd7);
    check_wr("t2_w2", 2, 16'h0150, 16'h2000);
    check_wr("t2_w3", 3, 16'h01D0, 16'h0100);
    check_wr("t2_w4", 4, 16'h068A, 16'd5);

    // T3: full table drops the report with no writes
    preload(16'h068A, 16'd64);
    wbase = wlog_a.size();
    send("t3", 16'h0077, 16'd1, 16'd1, 16'd1, lat, st);
    check("t3_lat", 32'(lat), 32'd67);
    check("t3_status", 32'(st), 32'd2);
    check("t3_nwr", 32'(wlog_a.size() - wbase), 32'd0);

    // Stored count above capacity clamps to 64
    preload(16'h068A, 16'h0100);
    wbase = wlog_a.size();
    send("t3b", 16'h0078, 16'd1, 16'd1, 16'd1, lat, st);
    check("t3b_lat", 32'(lat), 32'd67);
    check("t3b_status", 32'(st), 32'd2);
    check("t3b_nwr", 32'(wlog_a.size() - wbase), 32'd0);
    check("t3b_cnt", 32'(rd_word(16'h068A)), 32'h100);

    // T4: empty table appends at index 0
    preload(16'h068A, 16'd0);
    wbase = wlog_a.size();
    send("t4", 16'd2, 16'h0011, 16'h0000, 16'h0000, lat, st);
    check("t4_lat", 32'(lat), 32'd8);
    check("t4_status", 32'(st), 32'd1);
    check_wr("t4_w0", 0, 16'h0048, 16'd2);
    check_wr("t4_w4", 4, 16'h068A, 16'd1);

    // T6: in_valid held across two back-to-back reports
    wbase = wlog_a.size();
    @(negedge clock);
    in_id = 16'd5; in_cluster = 16'd1; in_battery = 16'h7FFF; in_qvalue = 16'h0002;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_id = 16'd2; in_cluster = 16'h0033; in_battery = 16'h1234; in_qvalue = 16'hFFFF;
    wait_done(lat, st);
    check("t6a_lat", 32'(lat), 32'd9);
    check("t6a_status", 32'(st), 32'd1);
    check("t6a_ready_in_done", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("t6_ready_after_done", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    wait_done(lat, st);
    check("t6b_lat", 32'(lat), 32'd6);
    check("t6b_status", 32'(st), 32'd0);
    check("t6_nwr", 32'(wlog_a.size() - wbase), 32'd8);
    check("t6_id1", 32'(rd_word(16'h004A)), 32'd5);
    check("t6_q1", 32'(rd_word(16'h01CA)), 32'h0002);
    check("t6_cl0", 32'(rd_word(16'h00C8)), 32'h0033);
    check("t6_bat0", 32'(rd_word(16'h0148)), 32'h1234);
    check("t6_cnt", 32'(rd_word(16'h068A)), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
